// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package regfile_wb_arbiter_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int RIDX_W = 5;

  // Requester IDs; also the bit positions in the arbiter request/grant vectors
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bundle (ALU and MEM requesters) plus register-file write port.
// Latency: n/a (wires only).
// Backpressure: valid/ready per requester; the write port has no backpressure.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = regfile_wb_arbiter_pkg::XLEN
);
  import regfile_wb_arbiter_pkg::*;

  logic              alu_valid;
  logic [RIDX_W-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [RIDX_W-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              mem_ready;

  logic              RegWrite;
  logic [RIDX_W-1:0] rd;
  logic [XLEN-1:0]   WriteData;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, RegWrite, rd, WriteData
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, RegWrite, rd, WriteData
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin grant with a favoured-requester pointer.
// Latency: grant is combinational from req/en; pointer updates on the clock edge.
// Backpressure: no grant while en is low; the loser of a contest simply waits.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Requester that wins the next contested cycle
  logic ptr;

  // Grant: a lone request always wins, a contest goes to the pointer
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) begin
        gnt[ptr] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer moves only after a contested grant so uncontested traffic leaves fairness untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= REQ_ALU;
    end else if (en && (&req)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port; sweeps x1..x31 to zero on request.
// Latency: one cycle from accepted request (or clear step) to registered RegWrite/rd/WriteData.
// Backpressure: ready withheld from the losing requester, during the sweep, and on a clear_start cycle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
  parameter int NREG = regfile_wb_arbiter_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus,
  input  logic                 clear_start,
  output logic                 busy,
  output logic [15:0]          conflict_cnt
);

  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NREG - 1);

  state_t            state;
  logic [RIDX_W-1:0] clr_idx;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              arb_en;

  assign req[REQ_ALU] = bus.alu_valid;
  assign req[REQ_MEM] = bus.mem_valid;

  // Clear wins over writeback, and nothing is granted while reset is held
  assign arb_en = !reset && (state == IDLE) && !clear_start;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.alu_ready = gnt[REQ_ALU];
  assign bus.mem_ready = gnt[REQ_MEM];

  // FSM, clear sweep, conflict counter and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.RegWrite  <= 1'b0;
      bus.rd        <= '0;
      bus.WriteData <= '0;
      busy          <= 1'b0;
      clr_idx       <= RIDX_W'(1);
      conflict_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.RegWrite <= 1'b0;
          // Contention is counted even on a clear_start cycle where nobody is granted
          if (bus.alu_valid && bus.mem_valid && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
          end
          if (clear_start) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_idx <= RIDX_W'(1);
          end else if (gnt[REQ_ALU]) begin
            // x0 writes complete the handshake but never reach the register file
            bus.RegWrite  <= (bus.alu_rd != '0);
            bus.rd        <= bus.alu_rd;
            bus.WriteData <= bus.alu_data;
          end else if (gnt[REQ_MEM]) begin
            bus.RegWrite  <= (bus.mem_rd != '0);
            bus.rd        <= bus.mem_rd;
            bus.WriteData <= bus.mem_data;
          end
        end
        CLEAR: begin
          bus.RegWrite  <= 1'b1;
          bus.rd        <= clr_idx;
          bus.WriteData <= '0;
          if (clr_idx == LAST_IDX) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_idx <= RIDX_W'(1);
          end else begin
            clr_idx <= clr_idx + RIDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed stimulus for regfile_wb_arbiter with a queue-based reference model.
// Latency: model expects each accepted write exactly one cycle after acceptance.
// Backpressure: driver holds rd/data stable until its request is accepted.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_start;
  logic        busy;
  logic [15:0] conflict_cnt;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_t;

  wb_t exp_q[$];   // writes the register file must see, in order, one per cycle
  int  clr_q[$];   // register indices still owed by an active sweep
  bit  turn_mem;   // model: next contest goes to MEM
  int  m_cnt;      // model conflict count

  regfile_wb_arbiter_if #(.XLEN(64)) bus ();

  regfile_wb_arbiter #(.XLEN(64), .NREG(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .clear_start  (clear_start),
    .busy         (busy),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model and monitor, sampled mid-cycle
  always @(negedge clk) begin
    bit  ea, em, idle, both;
    wb_t w;
    if (reset) begin
      chk("reset_regwrite", 64'(bus.RegWrite), 64'd0);
      chk("reset_rd", 64'(bus.rd), 64'd0);
      chk("reset_wdata", bus.WriteData, 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_ready", 64'({bus.alu_ready, bus.mem_ready}), 64'd0);
      chk("reset_conflict", 64'(conflict_cnt), 64'd0);
      exp_q.delete();
      clr_q.delete();
      turn_mem = 1'b0;
      m_cnt    = 0;
    end else begin
      chk("write_enable", 64'(bus.RegWrite), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        if (bus.RegWrite) begin
          chk("write_rd", 64'(bus.rd), 64'(w.rd));
          chk("write_data", bus.WriteData, w.data);
        end
      end
      chk("busy", 64'(busy), 64'(clr_q.size() != 0));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));

      idle = (clr_q.size() == 0);
      both = bus.alu_valid && bus.mem_valid;
      ea = 1'b0;
      em = 1'b0;
      if (idle && !clear_start) begin
        if (both) begin
          ea = !turn_mem;
          em = turn_mem;
          turn_mem = !turn_mem;
        end else begin
          ea = bus.alu_valid;
          em = bus.mem_valid;
        end
      end
      chk("ready", 64'({bus.alu_ready, bus.mem_ready}), 64'({ea, em}));
      if (idle && both && m_cnt < 65535) m_cnt++;

      if (!idle) begin
        w.rd   = 5'(clr_q.pop_front());
        w.data = 64'd0;
        exp_q.push_back(w);
      end else if (clear_start) begin
        for (int i = 1; i < 32; i++) clr_q.push_back(i);
      end else if (ea && bus.alu_rd != 5'd0) begin
        w.rd   = bus.alu_rd;
        w.data = bus.alu_data;
        exp_q.push_back(w);
      end else if (em && bus.mem_rd != 5'd0) begin
        w.rd   = bus.mem_rd;
        w.data = bus.mem_data;
        exp_q.push_back(w);
      end
    end
  end

  initial begin
    bit af, mf, found;
    reset         = 1'b1;
    clear_start   = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Lone ALU request: accepted, written one cycle later, then held
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
    #1 chk("alu_alone_ready", 64'(bus.alu_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_alone_we", 64'(bus.RegWrite), 64'd1);
    chk("alu_alone_rd", 64'(bus.rd), 64'd5);
    chk("alu_alone_data", bus.WriteData, 64'h1234);
    tick();
    chk("idle_we", 64'(bus.RegWrite), 64'd0);
    chk("hold_rd", 64'(bus.rd), 64'd5);
    chk("hold_data", bus.WriteData, 64'h1234);

    // Four contested cycles alternate ALU, MEM, ALU, MEM
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 64'hA6;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 64'hB7;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_order_rd", 64'(bus.rd), (i % 2 == 0) ? 64'd6 : 64'd7);
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    chk("rr_conflict4", 64'(conflict_cnt), 64'd4);

    // Load to x0: handshake completes, no write
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 64'hDEAD;
    #1 chk("x0_ready", 64'(bus.mem_ready), 64'd1);
    tick();
    bus.mem_valid = 1'b0;
    chk("x0_we", 64'(bus.RegWrite), 64'd0);

    // Clear sweep with an ALU request waiting
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 64'h99;
    clear_start = 1'b1;
    #1 chk("clr_start_ready", 64'(bus.alu_ready), 64'd0);
    tick();
    clear_start = 1'b0;
    for (int j = 1; j < 32; j++) begin
      #1 chk("clr_ready", 64'(bus.alu_ready), 64'd0);
      tick();
      chk("clr_we", 64'(bus.RegWrite), 64'd1);
      chk("clr_rd", 64'(bus.rd), 64'(j));
      chk("clr_data", bus.WriteData, 64'd0);
    end
    chk("clr_done_busy", 64'(busy), 64'd0);
    #1 chk("clr_done_ready", 64'(bus.alu_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    chk("post_clr_rd", 64'(bus.rd), 64'd9);

    // Reset arriving at the rd=10 sweep write aborts the sweep
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (bus.RegWrite && bus.rd == 5'd10) found = 1'b1;
    end
    chk("sweep_reach_rd10", 64'(found), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_we", 64'(bus.RegWrite), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (40) tick();

    // Random traffic, holding each request stable until accepted
    repeat (3000) begin
      @(negedge clk);
      af = bus.alu_valid && bus.alu_ready;
      mf = bus.mem_valid && bus.mem_ready;
      @(posedge clk);
      #1;
      if (!bus.alu_valid || af) begin
        bus.alu_valid = ($urandom_range(0, 2) != 0);
        bus.alu_rd    = 5'($urandom);
        bus.alu_data  = {$urandom, $urandom};
      end
      if (!bus.mem_valid || mf) begin
        bus.mem_valid = ($urandom_range(0, 2) != 0);
        bus.mem_rd    = 5'($urandom);
        bus.mem_data  = {$urandom, $urandom};
      end
      clear_start = ($urandom_range(0, 60) == 0);
    end
    clear_start = 1'b0;

    // Long contested run drives the conflict counter into saturation
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h3;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 64'h4;
    repeat (65600) tick();
    chk("conflict_saturated", 64'(conflict_cnt), 64'hFFFF);
    tick();
    chk("conflict_hold", 64'(conflict_cnt), 64'hFFFF);
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    repeat (40) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
